// File: rtl/bus_rr_scheduler.sv
// -----------------------------------------------------------------------------
// bus_rr_scheduler
//
// Round-robin scheduler that shares one broadcast bus among DRVS show-ahead
// device FIFOs. It picks a pending source, pops one packet from it, decodes
// the destination ID held in the packet's top byte and pushes the packet to
// the destination FIFO(s). A blocked destination is retried for up to TIMEOUT
// cycles before the packet is dropped.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   pndng     in   [DRVS]        FIFO i is non-empty
//   D_pop     in   [DRVS*WIDTH]  head word of FIFO i at [i*WIDTH +: WIDTH]
//   pop       out  [DRVS]        one-hot, one-cycle pop strobe
//   full      in   [DRVS]        FIFO i cannot accept a push
//   push      out  [DRVS]        push strobe mask (several bits on broadcast)
//   D_push    out  [WIDTH]       push data, common to all destinations
//   busy      out                FSM is not idle
//   grant_id  out  [4]           current or last granted source
//   drop_cnt  out  [16]          saturating count of dropped packets
// -----------------------------------------------------------------------------
module bus_rr_scheduler #(
  parameter int          WIDTH     = 16,
  parameter int          DRVS      = 8,
  parameter logic [7:0]  BROADCAST = 8'hFF,
  parameter int          TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DRVS-1:0]       pndng,
  input  logic [DRVS*WIDTH-1:0] D_pop,
  output logic [DRVS-1:0]       pop,
  input  logic [DRVS-1:0]       full,
  output logic [DRVS-1:0]       push,
  output logic [WIDTH-1:0]      D_push,
  output logic                  busy,
  output logic [3:0]            grant_id,
  output logic [15:0]           drop_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POP    = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] PUSH   = 2'd3;

  localparam logic [DRVS-1:0] ONE       = {{(DRVS-1){1'b0}}, 1'b1};
  localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [3:0]       rr_ptr;
  logic [WIDTH-1:0] pkt;
  logic [WIDTH-1:0] last_push;
  logic [DRVS-1:0]  mask;
  logic [15:0]      wait_cnt;

  logic             found;
  logic [3:0]       next_grant;
  logic [7:0]       dst;
  logic             push_fire;

  // Round-robin search: the first pending source strictly after rr_ptr,
  // wrapping modulo DRVS, so the last serviced source ends up lowest priority.
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    for (int k = 1; k <= DRVS; k++) begin
      if (!found && pndng[(int'(rr_ptr) + k) % DRVS]) begin
        found      = 1'b1;
        next_grant = 4'((int'(rr_ptr) + k) % DRVS);
      end
    end
  end

  // Strobes are decoded from the state so that pop and push land in the same
  // cycle the FIFOs see them; D_push shows the packet while it is written and
  // otherwise keeps the last delivered word.
  always_comb begin
    dst       = pkt[WIDTH-1 -: 8];
    push_fire = (state == PUSH) && ((mask & full) == '0);
    pop       = (state == POP) ? (ONE << grant_id) : '0;
    push      = push_fire ? mask : '0;
    D_push    = push_fire ? pkt : last_push;
    busy      = (state != IDLE);
  end

  // Main sequencer: IDLE -> POP -> DECODE -> PUSH. Both drop paths leave
  // the dropped source as the lowest priority, exactly like a delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 4'(DRVS - 1);
      grant_id  <= '0;
      drop_cnt  <= '0;
      pkt       <= '0;
      last_push <= '0;
      mask      <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= next_grant;
            state    <= POP;
          end
        end
        POP: begin
          pkt   <= D_pop[int'(grant_id)*WIDTH +: WIDTH];
          state <= DECODE;
        end
        DECODE: begin
          wait_cnt <= '0;
          // A self-addressed packet falls into the ordinary one-hot case.
          if (int'(dst) < DRVS) begin
            mask  <= ONE << dst;
            state <= PUSH;
          end else if (dst == BROADCAST) begin
            mask  <= ~(ONE << grant_id);
            state <= PUSH;
          end else begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            rr_ptr <= grant_id;
            state  <= IDLE;
          end
        end
        PUSH: begin
          if (push_fire) begin
            last_push <= pkt;
            rr_ptr    <= grant_id;
            state     <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            rr_ptr <= grant_id;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
